// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: slices the fetched instruction into
// register-file read addresses, decodes control, sign-extends the immediate,
// detects load-use hazards and registers everything into the ID/EX latch.
module decode_stage #(
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [0:31]                instrIn,
    input  logic                       instrValid,
    input  logic [0:31]                pcIn,
    input  logic                       flush,
    input  logic [0:31]                rsData,
    input  logic [0:31]                rtData,
    output logic [0:4]                 rsAddr,
    output logic [0:4]                 rtAddr,
    output logic                       stallOut,
    output logic                       exValid,
    output logic [0:31]                exPc,
    output logic [0:31]                exRsVal,
    output logic [0:31]                exRtVal,
    output logic [0:31]                exImm,
    output logic [0:4]                 exDest,
    output logic [0:2]                 exAluOp,
    output logic                       exRegWrite,
    output logic                       exMemRead,
    output logic                       exMemWrite,
    output logic                       exBranch,
    output logic                       exAluSrcImm,
    output logic                       illegalOut,
    output logic [0:STALL_CNT_WIDTH-1] stallCount
);

    localparam logic [0:5] OP_RTYPE = 6'b000000;
    localparam logic [0:5] OP_ADDI  = 6'b001000;
    localparam logic [0:5] OP_LW    = 6'b100011;
    localparam logic [0:5] OP_SW    = 6'b101011;
    localparam logic [0:5] OP_BEQ   = 6'b000100;

    localparam logic [0:5] FN_ADD = 6'b100000;
    localparam logic [0:5] FN_SUB = 6'b100010;
    localparam logic [0:5] FN_AND = 6'b100100;
    localparam logic [0:5] FN_OR  = 6'b100101;
    localparam logic [0:5] FN_SLT = 6'b101010;

    localparam logic [0:2] ALU_ADD = 3'b000;
    localparam logic [0:2] ALU_SUB = 3'b001;
    localparam logic [0:2] ALU_AND = 3'b010;
    localparam logic [0:2] ALU_OR  = 3'b011;
    localparam logic [0:2] ALU_SLT = 3'b100;

    localparam logic [0:STALL_CNT_WIDTH-1] CNT_MAX = {STALL_CNT_WIDTH{1'b1}};

    // Instruction fields
    logic [0:5]  opcode_s;
    logic [0:4]  rs_s;
    logic [0:4]  rt_s;
    logic [0:4]  rd_s;
    logic [0:5]  funct_s;
    logic [0:15] imm_s;
    logic [0:31] imm_ext_s;

    // Decoded controls
    logic        legal_s;
    logic        uses_rt_s;
    logic [0:4]  dest_s;
    logic [0:2]  alu_op_s;
    logic        reg_write_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        branch_s;
    logic        alu_src_imm_s;
    logic        hazard_s;
    logic        stall_s;

    // ID/EX register state
    logic                       ex_valid_q, ex_valid_d;
    logic [0:31]                ex_pc_q, ex_pc_d;
    logic [0:31]                ex_rs_val_q, ex_rs_val_d;
    logic [0:31]                ex_rt_val_q, ex_rt_val_d;
    logic [0:31]                ex_imm_q, ex_imm_d;
    logic [0:4]                 ex_dest_q, ex_dest_d;
    logic [0:2]                 ex_alu_op_q, ex_alu_op_d;
    logic                       ex_reg_write_q, ex_reg_write_d;
    logic                       ex_mem_read_q, ex_mem_read_d;
    logic                       ex_mem_write_q, ex_mem_write_d;
    logic                       ex_branch_q, ex_branch_d;
    logic                       ex_alu_src_imm_q, ex_alu_src_imm_d;
    logic                       illegal_q, illegal_d;
    logic [0:STALL_CNT_WIDTH-1] stall_count_q, stall_count_d;

    assign opcode_s  = instrIn[0:5];
    assign rs_s      = instrIn[6:10];
    assign rt_s      = instrIn[11:15];
    assign rd_s      = instrIn[16:20];
    assign funct_s   = instrIn[26:31];
    assign imm_s     = instrIn[16:31];
    assign imm_ext_s = {{16{imm_s[0]}}, imm_s};

    assign rsAddr = rs_s;
    assign rtAddr = rt_s;

    // Decode opcode/funct into destination, ALU op, controls and source usage
    always_comb begin
        legal_s       = 1'b0;
        uses_rt_s     = 1'b0;
        dest_s        = 5'd0;
        alu_op_s      = ALU_ADD;
        reg_write_s   = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        branch_s      = 1'b0;
        alu_src_imm_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dest_s      = rd_s;
                reg_write_s = 1'b1;
                uses_rt_s   = 1'b1;
                legal_s     = 1'b1;
                case (funct_s)
                    FN_ADD:  alu_op_s = ALU_ADD;
                    FN_SUB:  alu_op_s = ALU_SUB;
                    FN_AND:  alu_op_s = ALU_AND;
                    FN_OR:   alu_op_s = ALU_OR;
                    FN_SLT:  alu_op_s = ALU_SLT;
                    default: legal_s  = 1'b0;
                endcase
            end
            OP_ADDI: begin
                legal_s       = 1'b1;
                dest_s        = rt_s;
                alu_src_imm_s = 1'b1;
                reg_write_s   = 1'b1;
            end
            OP_LW: begin
                legal_s       = 1'b1;
                dest_s        = rt_s;
                alu_src_imm_s = 1'b1;
                mem_read_s    = 1'b1;
                reg_write_s   = 1'b1;
            end
            OP_SW: begin
                legal_s       = 1'b1;
                uses_rt_s     = 1'b1;
                alu_src_imm_s = 1'b1;
                mem_write_s   = 1'b1;
            end
            OP_BEQ: begin
                legal_s   = 1'b1;
                uses_rt_s = 1'b1;
                alu_op_s  = ALU_SUB;
                branch_s  = 1'b1;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // Load-use hazard: a load in EX whose non-zero destination feeds a source here
    always_comb begin
        hazard_s = 1'b0;
        if (instrValid && legal_s && ex_valid_q && ex_mem_read_q && (ex_dest_q != 5'd0)) begin
            hazard_s = (ex_dest_q == rs_s) || (uses_rt_s && (ex_dest_q == rt_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Flush outranks stall, so a flushed hazard never stalls fetch
    assign stall_s  = hazard_s && !flush;
    assign stallOut = stall_s;

    // Next-state for the ID/EX latch: flush, empty slot, illegal, stall, or issue
    always_comb begin
        ex_valid_d       = 1'b0;
        ex_pc_d          = pcIn;
        ex_rs_val_d      = rsData;
        ex_rt_val_d      = rtData;
        ex_imm_d         = imm_ext_s;
        ex_dest_d        = 5'd0;
        ex_alu_op_d      = ALU_ADD;
        ex_reg_write_d   = 1'b0;
        ex_mem_read_d    = 1'b0;
        ex_mem_write_d   = 1'b0;
        ex_branch_d      = 1'b0;
        ex_alu_src_imm_d = 1'b0;
        illegal_d        = 1'b0;
        stall_count_d    = stall_count_q;
        if (flush || !instrValid) begin
            illegal_d = 1'b0;
        end else if (!legal_s) begin
            illegal_d = 1'b1;
        end else if (stall_s) begin
            if (stall_count_q != CNT_MAX) begin
                stall_count_d = stall_count_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stall_count_d = stall_count_q;
            end
        end else begin
            ex_valid_d       = 1'b1;
            ex_dest_d        = dest_s;
            ex_alu_op_d      = alu_op_s;
            ex_reg_write_d   = reg_write_s;
            ex_mem_read_d    = mem_read_s;
            ex_mem_write_d   = mem_write_s;
            ex_branch_d      = branch_s;
            ex_alu_src_imm_d = alu_src_imm_s;
        end
    end

    // ID/EX pipeline register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q       <= 1'b0;
            ex_pc_q          <= 32'd0;
            ex_rs_val_q      <= 32'd0;
            ex_rt_val_q      <= 32'd0;
            ex_imm_q         <= 32'd0;
            ex_dest_q        <= 5'd0;
            ex_alu_op_q      <= 3'd0;
            ex_reg_write_q   <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_branch_q      <= 1'b0;
            ex_alu_src_imm_q <= 1'b0;
            illegal_q        <= 1'b0;
            stall_count_q    <= {STALL_CNT_WIDTH{1'b0}};
        end else begin
            ex_valid_q       <= ex_valid_d;
            ex_pc_q          <= ex_pc_d;
            ex_rs_val_q      <= ex_rs_val_d;
            ex_rt_val_q      <= ex_rt_val_d;
            ex_imm_q         <= ex_imm_d;
            ex_dest_q        <= ex_dest_d;
            ex_alu_op_q      <= ex_alu_op_d;
            ex_reg_write_q   <= ex_reg_write_d;
            ex_mem_read_q    <= ex_mem_read_d;
            ex_mem_write_q   <= ex_mem_write_d;
            ex_branch_q      <= ex_branch_d;
            ex_alu_src_imm_q <= ex_alu_src_imm_d;
            illegal_q        <= illegal_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign exValid     = ex_valid_q;
    assign exPc        = ex_pc_q;
    assign exRsVal     = ex_rs_val_q;
    assign exRtVal     = ex_rt_val_q;
    assign exImm       = ex_imm_q;
    assign exDest      = ex_dest_q;
    assign exAluOp     = ex_alu_op_q;
    assign exRegWrite  = ex_reg_write_q;
    assign exMemRead   = ex_mem_read_q;
    assign exMemWrite  = ex_mem_write_q;
    assign exBranch    = ex_branch_q;
    assign exAluSrcImm = ex_alu_src_imm_q;
    assign illegalOut  = illegal_q;
    assign stallCount  = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

    localparam int W = 4;

    logic          clock;
    logic          reset;
    logic [0:31]   instrIn;
    logic          instrValid;
    logic [0:31]   pcIn;
    logic          flush;
    logic [0:31]   rsData;
    logic [0:31]   rtData;
    logic [0:4]    rsAddr;
    logic [0:4]    rtAddr;
    logic          stallOut;
    logic          exValid;
    logic [0:31]   exPc;
    logic [0:31]   exRsVal;
    logic [0:31]   exRtVal;
    logic [0:31]   exImm;
    logic [0:4]    exDest;
    logic [0:2]    exAluOp;
    logic          exRegWrite;
    logic          exMemRead;
    logic          exMemWrite;
    logic          exBranch;
    logic          exAluSrcImm;
    logic          illegalOut;
    logic [0:W-1]  stallCount;

    int vectors;
    int miscompares;

    decode_stage #(.STALL_CNT_WIDTH(W)) dut (
        .clock(clock), .reset(reset), .instrIn(instrIn), .instrValid(instrValid),
        .pcIn(pcIn), .flush(flush), .rsData(rsData), .rtData(rtData),
        .rsAddr(rsAddr), .rtAddr(rtAddr), .stallOut(stallOut), .exValid(exValid),
        .exPc(exPc), .exRsVal(exRsVal), .exRtVal(exRtVal), .exImm(exImm),
        .exDest(exDest), .exAluOp(exAluOp), .exRegWrite(exRegWrite),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exBranch(exBranch),
        .exAluSrcImm(exAluSrcImm), .illegalOut(illegalOut), .stallCount(stallCount)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then let outputs settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic v, input logic f);
        instrIn    = ins;
        instrValid = v;
        flush      = f;
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; instrIn = 32'd0; instrValid = 1'b0; pcIn = 32'd0;
        flush = 1'b0; rsData = 32'd0; rtData = 32'd0;
        tick();
        tick();
        chk("rst_valid", exValid, 32'd0);
        chk("rst_dest", exDest, 32'd0);
        chk("rst_imm", exImm, 32'd0);
        chk("rst_illegal", illegalOut, 32'd0);
        chk("rst_count", stallCount, 32'd0);
        reset = 1'b0;

        // add $3,$1,$2
        rsData = 32'd5; rtData = 32'd7; pcIn = 32'h100;
        present(32'h00221820, 1'b1, 1'b0);
        chk("add_rsaddr", rsAddr, 32'd1);
        chk("add_rtaddr", rtAddr, 32'd2);
        chk("add_stall", stallOut, 32'd0);
        tick();
        chk("add_valid", exValid, 32'd1);
        chk("add_dest", exDest, 32'd3);
        chk("add_aluop", exAluOp, 32'd0);
        chk("add_rsval", exRsVal, 32'd5);
        chk("add_rtval", exRtVal, 32'd7);
        chk("add_regwr", exRegWrite, 32'd1);
        chk("add_pc", exPc, 32'h100);

        // addi $5,$0,-1
        present(32'h2005FFFF, 1'b1, 1'b0);
        tick();
        chk("addi_imm", exImm, 32'hFFFFFFFF);
        chk("addi_dest", exDest, 32'd5);
        chk("addi_srcimm", exAluSrcImm, 32'd1);
        chk("addi_memrd", exMemRead, 32'd0);

        // slt $3,$1,$2 and or $3,$1,$2
        present(32'h0022182A, 1'b1, 1'b0);
        tick();
        chk("slt_aluop", exAluOp, 32'd4);
        present(32'h00221825, 1'b1, 1'b0);
        tick();
        chk("or_aluop", exAluOp, 32'd3);

        // beq $1,$2,3
        present(32'h10220003, 1'b1, 1'b0);
        tick();
        chk("beq_branch", exBranch, 32'd1);
        chk("beq_aluop", exAluOp, 32'd1);
        chk("beq_regwr", exRegWrite, 32'd0);
        chk("beq_imm", exImm, 32'd3);

        // sw $2,8($1)
        present(32'hAC220008, 1'b1, 1'b0);
        tick();
        chk("sw_memwr", exMemWrite, 32'd1);
        chk("sw_regwr", exRegWrite, 32'd0);

        // lw $2,4($1) then add $3,$2,$1: one-cycle stall
        present(32'h8C220004, 1'b1, 1'b0);
        tick();
        chk("lw_memrd", exMemRead, 32'd1);
        chk("lw_dest", exDest, 32'd2);
        chk("lw_imm", exImm, 32'd4);
        present(32'h00411820, 1'b1, 1'b0);
        chk("hz_stall", stallOut, 32'd1);
        tick();
        chk("hz_bubble", exValid, 32'd0);
        chk("hz_count", stallCount, 32'd1);
        chk("hz_restall", stallOut, 32'd0);
        tick();
        chk("hz_issue_valid", exValid, 32'd1);
        chk("hz_issue_dest", exDest, 32'd3);

        // lw $0 then a use of $0: no stall
        present(32'h8C200000, 1'b1, 1'b0);
        tick();
        present(32'h00011820, 1'b1, 1'b0);
        chk("r0_stall", stallOut, 32'd0);
        tick();
        chk("r0_valid", exValid, 32'd1);
        chk("r0_count", stallCount, 32'd1);

        // Hazard pair with flush on the consumer
        present(32'h8C220004, 1'b1, 1'b0);
        tick();
        present(32'h00411820, 1'b1, 1'b1);
        chk("fl_stall", stallOut, 32'd0);
        tick();
        chk("fl_valid", exValid, 32'd0);
        chk("fl_count", stallCount, 32'd1);

        // Illegal opcode pulses illegalOut for one cycle
        present(32'hFC000000, 1'b1, 1'b0);
        tick();
        chk("ill_flag", illegalOut, 32'd1);
        chk("ill_valid", exValid, 32'd0);
        present(32'h00221820, 1'b0, 1'b0);
        tick();
        chk("ill_pulse", illegalOut, 32'd0);
        chk("nv_valid", exValid, 32'd0);

        // Illegal funct under flush does not flag
        present(32'h00000001, 1'b1, 1'b1);
        tick();
        chk("illfl_flag", illegalOut, 32'd0);
        // Illegal funct without flush does
        present(32'h00000001, 1'b1, 1'b0);
        tick();
        chk("illfn_flag", illegalOut, 32'd1);

        // Saturation: lw $2,0($2) held stalls every other cycle
        present(32'h8C420000, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        chk("sat_count", stallCount, 32'hF);

        // Reset while a stall is pending
        for (int i = 0; i < 4 && !stallOut; i++) begin
            tick();
        end
        chk("mid_stall_pre", stallOut, 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_valid", exValid, 32'd0);
        chk("mid_memrd", exMemRead, 32'd0);
        chk("mid_dest", exDest, 32'd0);
        chk("mid_rsval", exRsVal, 32'd0);
        chk("mid_imm", exImm, 32'd0);
        chk("mid_count", stallCount, 32'd0);
        chk("mid_stall_post", stallOut, 32'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
